// File: rtl/parallel_to_serial.sv
// Byte-wide to bit-serial transmitter, MSB first, COM-filled line.
// Sends a COM preamble after every reset so the receiver can align.
module parallel_to_serial #(
   parameter int                WIDTH      = 8,
   parameter logic [WIDTH-1:0]  COM_SYMBOL = 8'hBC,
   parameter int                SYNC_COUNT = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] DATA_IN,
   input  logic             VALID_IN,
   output logic             READY_OUT,
   output logic             DATA_OUT,
   output logic             BYTE_START,
   output logic             IS_DATA
);

   localparam int CW = $clog2(WIDTH);
   localparam int SW = $clog2(SYNC_COUNT + 1);

   localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
   localparam logic [SW-1:0] SYM_LAST = SW'(SYNC_COUNT - 1);

   localparam logic [1:0] ST_RST  = 2'd0;
   localparam logic [1:0] ST_SYNC = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    bit_cnt;
   logic [SW-1:0]    sym_cnt;
   logic [WIDTH-1:0] hold;
   logic             hold_full;
   logic             byte_start_r;
   logic             is_data_r;
   logic             boundary;
   logic             accept;
   logic             last_sync;

   assign READY_OUT  = (state != ST_RST) && !hold_full;
   assign DATA_OUT   = shreg[WIDTH-1];
   assign BYTE_START = byte_start_r;
   assign IS_DATA    = is_data_r;

   assign boundary  = (bit_cnt == BIT_LAST);
   assign accept    = VALID_IN && READY_OUT;
   assign last_sync = (state != ST_SYNC) || (sym_cnt == SYM_LAST);

   // Accept and consume are exclusive: accept needs hold_full low.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state        <= ST_RST;
         shreg        <= '0;
         bit_cnt      <= '0;
         sym_cnt      <= '0;
         hold         <= '0;
         hold_full    <= 1'b0;
         byte_start_r <= 1'b0;
         is_data_r    <= 1'b0;
      end else begin
         if (accept) begin
            hold      <= DATA_IN;
            hold_full <= 1'b1;
         end
         case (state)
            ST_RST: begin
               state        <= ST_SYNC;
               shreg        <= COM_SYMBOL;
               bit_cnt      <= '0;
               sym_cnt      <= '0;
               byte_start_r <= 1'b1;
               is_data_r    <= 1'b0;
            end
            default: begin
               if (boundary) begin
                  bit_cnt      <= '0;
                  byte_start_r <= 1'b1;
                  if (!last_sync) begin
                     sym_cnt   <= sym_cnt + 1'b1;
                     shreg     <= COM_SYMBOL;
                     is_data_r <= 1'b0;
                  end else begin
                     state <= ST_RUN;
                     if (hold_full) begin
                        shreg     <= hold;
                        hold_full <= 1'b0;
                        is_data_r <= 1'b1;
                     end else begin
                        shreg     <= COM_SYMBOL;
                        is_data_r <= 1'b0;
                     end
                  end
               end else begin
                  shreg        <= {shreg[WIDTH-2:0], 1'b0};
                  bit_cnt      <= bit_cnt + 1'b1;
                  byte_start_r <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Randomized bench for parallel_to_serial against an edge-count
// based model of the symbol stream.
module tb_parallel_to_serial;

   localparam int         W   = 8;
   localparam logic [7:0] COM = 8'hBC;
   localparam int         SC  = 4;
   localparam int         NCYC = 3000;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic [7:0] DATA_IN = '0;
   logic       VALID_IN = 1'b0;
   logic       READY_OUT;
   logic       DATA_OUT;
   logic       BYTE_START;
   logic       IS_DATA;

   int n_vec = 0;
   int n_err = 0;

   int         m_k;
   bit         m_pend_full;
   logic [7:0] m_pend;
   logic [7:0] m_cur;
   bit         m_isd;
   bit         m_acc;

   parallel_to_serial dut (
      .CLK(CLK),
      .RESET(RESET),
      .DATA_IN(DATA_IN),
      .VALID_IN(VALID_IN),
      .READY_OUT(READY_OUT),
      .DATA_OUT(DATA_OUT),
      .BYTE_START(BYTE_START),
      .IS_DATA(IS_DATA)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_k = 0;
      m_pend_full = 1'b0;
      m_cur = '0;
      m_isd = 1'b0;
      m_acc = 1'b0;
   endtask

   // Edge k+1 after release: symbol index k/W, bit position k%W.
   task automatic model_edge(input bit v, input logic [7:0] d);
      int p;
      int s;
      bit rdy;
      p = m_k % W;
      s = m_k / W;
      rdy = (m_k > 0) && !m_pend_full;
      m_acc = v && rdy;
      if (p == 0) begin
         if (s < SC) begin
            m_cur = COM;
            m_isd = 1'b0;
         end else if (m_pend_full) begin
            m_cur = m_pend;
            m_isd = 1'b1;
            m_pend_full = 1'b0;
         end else begin
            m_cur = COM;
            m_isd = 1'b0;
         end
      end
      if (m_acc) begin
         m_pend = d;
         m_pend_full = 1'b1;
      end
      m_k++;
   endtask

   task automatic check_outputs();
      int p;
      logic [7:0] c;
      p = (m_k - 1) % W;
      c = m_cur;
      check("DATA_OUT", 32'(DATA_OUT), 32'(c[W-1-p]));
      check("BYTE_START", 32'(BYTE_START), 32'(p == 0));
      check("IS_DATA", 32'(IS_DATA), 32'(m_isd));
      check("READY_OUT", 32'(READY_OUT), 32'(!m_pend_full));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_DATA_OUT"}, 32'(DATA_OUT), 32'd0);
      check({tag, "_BYTE_START"}, 32'(BYTE_START), 32'd0);
      check({tag, "_IS_DATA"}, 32'(IS_DATA), 32'd0);
      check({tag, "_READY_OUT"}, 32'(READY_OUT), 32'd0);
   endtask

   // Reset asserted mid-cycle; outputs must drop at once.
   task automatic pulse_reset(input int cycles);
      #2;
      RESET = 1'b0;
      #1;
      check_zero("rst_async");
      model_reset();
      repeat (cycles) begin
         @(posedge CLK);
         #1;
         check_zero("rst_hold");
      end
      @(negedge CLK);
      RESET = 1'b1;
   endtask

   initial begin
      int rate;
      bit mid_done;
      bit v;
      logic [7:0] d;
      mid_done = 1'b0;
      model_reset();
      repeat (5) @(posedge CLK);
      #1;
      check_zero("reset");
      @(negedge CLK);
      RESET = 1'b1;
      for (int i = 0; i < NCYC; i++) begin
         rate = (i < 300) ? 0 : (i < 1500) ? 100 : 30;
         @(posedge CLK);
         v = VALID_IN;
         d = DATA_IN;
         model_edge(v, d);
         #1;
         check_outputs();
         if (VALID_IN && m_acc)
            VALID_IN = 1'b0;
         if (!VALID_IN && ($urandom_range(99) < rate)) begin
            VALID_IN = 1'b1;
            DATA_IN = 8'($urandom);
         end else if (VALID_IN && m_pend_full && $urandom_range(3) == 0) begin
            DATA_IN = 8'($urandom);
         end
         if (!mid_done && m_isd && ((m_k - 1) % W == 3) && m_pend_full) begin
            mid_done = 1'b1;
            pulse_reset(3);
         end else if (i > 300 && $urandom_range(499) == 0) begin
            pulse_reset(1 + $urandom_range(4));
         end
      end
      check("mid_data_reset_hit", 32'(mid_done), 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
